// File: rtl/fc_arbiter.sv
// rtl/fc_arbiter.sv - four-source round-robin FIFO-to-FIFO arbiter with a two-stage pop-to-push pipeline
module fc_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       empty,
  input  logic [3:0]       almost_empty,
  input  logic [3:0]       cf,
  input  logic             almost_full_out,
  input  logic             full_out,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  output logic [3:0]       pop,
  output logic             push,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       state,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t     cur_state, nxt_state;
  logic [3:0] last_pop;
  logic [3:0] elig;
  logic       stall;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  logic       pop_en;
  logic       p1_valid;
  logic [1:0] p1_idx;

  assign stall = almost_full_out | full_out;

  // The flags lag the FIFOs by a cycle, so a source just popped while almost
  // empty may really be empty now; skip it for one cycle.
  assign elig = ~empty & cf & ~(last_pop & almost_empty);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = grant + 2'(k);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign pop_en = !reset && (cur_state != STALL) && !stall && sel_found;
  assign pop    = pop_en ? (4'b0001 << sel_idx) : 4'b0000;
  assign state  = cur_state;

  always_comb begin
    nxt_state = cur_state;
    if (stall) begin
      nxt_state = STALL;
    end else begin
      case (cur_state)
        IDLE:    nxt_state = sel_found ? SERVE : IDLE;
        SERVE:   nxt_state = sel_found ? SERVE : IDLE;
        STALL:   nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      grant     <= 2'd3;
      last_pop  <= 4'b0000;
      p1_valid  <= 1'b0;
      p1_idx    <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      last_pop  <= pop;
      p1_valid  <= pop_en;
      p1_idx    <= sel_idx;
      if (pop_en) begin
        grant <= sel_idx;
      end
    end
  end

  // Stage two: the source's read data is valid one cycle after its pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push     <= 1'b0;
      data_out <= '0;
    end else begin
      push <= p1_valid;
      if (p1_valid) begin
        case (p1_idx)
          2'd0:    data_out <= data_in0;
          2'd1:    data_out <= data_in1;
          2'd2:    data_out <= data_in2;
          default: data_out <= data_in3;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_arbiter.sv
// tb/tb_fc_arbiter.sv - randomized scoreboard bench for fc_arbiter
module tb_fc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] empty, almost_empty, cf;
  logic       almost_full_out, full_out;
  logic [5:0] din [4];
  logic [3:0] pop;
  logic       push;
  logic [5:0] data_out;
  logic [1:0] state, grant;

  fc_arbiter #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .empty(empty), .almost_empty(almost_empty), .cf(cf),
    .almost_full_out(almost_full_out), .full_out(full_out),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .pop(pop), .push(push), .data_out(data_out), .state(state), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] d;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  int         m_state;
  int         m_grant;
  logic [3:0] m_last;
  bit         pend_v;
  int         pend_idx;
  logic [5:0] m_dout;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: eligibility, round-robin choice and FSM from the rules.
  always @(negedge clk) begin
    logic [3:0] el;
    logic [3:0] exp_pop;
    bit         stl, can;
    int         ep;
    if (reset) begin
      chk("reset_pop", int'(pop), 0);
      chk("reset_state", int'(state), 0);
      chk("reset_grant", int'(grant), 3);
      m_state = 0;
      m_grant = 3;
      m_last  = 4'b0000;
      pend_v  = 0;
      q.delete();
    end else begin
      if (pend_v) q.push_back('{cyc + 1, din[pend_idx]});
      for (int i = 0; i < 4; i++)
        el[i] = !empty[i] && cf[i] && !(m_last[i] && almost_empty[i]);
      stl = almost_full_out || full_out;
      ep = -1;
      for (int k = 1; k <= 4; k++)
        if (ep < 0 && el[(m_grant + k) % 4]) ep = (m_grant + k) % 4;
      can = (m_state != 2) && !stl && (ep >= 0);
      exp_pop = can ? 4'(1 << ep) : 4'b0000;
      chk("pop", int'(pop), int'(exp_pop));
      chk("state", int'(state), m_state);
      chk("grant", int'(grant), m_grant);
      if (stl) m_state = 2;
      else if (m_state == 2) m_state = 0;
      else m_state = (ep >= 0) ? 1 : 0;
      if (can) m_grant = ep;
      pend_v   = can;
      pend_idx = can ? ep : 0;
      m_last   = exp_pop;
    end
  end

  // Monitor: every push must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_push", int'(push), 0);
      chk("reset_data_out", int'(data_out), 0);
      m_dout = '0;
    end else begin
      if (push) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          chk("push_data", int'(data_out), int'(q[0].d));
          m_dout = q[0].d;
          void'(q.pop_front());
        end else begin
          chk("unexpected_push", 1, 0);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("missing_push", 0, 1);
        void'(q.pop_front());
      end
      chk("data_out_hold", int'(data_out), int'(m_dout));
    end
  end

  task automatic drive(input logic [3:0] e, input logic [3:0] ae, input logic [3:0] c,
                       input logic afo, input logic fo, input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      empty = e; almost_empty = ae; cf = c;
      almost_full_out = afo; full_out = fo; reset = rst;
      for (int s = 0; s < 4; s++) din[s] = 6'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1; empty = 4'hF; almost_empty = 4'h0; cf = 4'hF;
    almost_full_out = 1'b0; full_out = 1'b0;
    for (int s = 0; s < 4; s++) din[s] = '0;
    drive(4'hF, 4'h0, 4'hF, 0, 0, 1, 3);
    drive(4'b1110, 4'h0, 4'hF, 0, 0, 0, 4);
    drive(4'hF, 4'h0, 4'hF, 0, 0, 0, 2);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 0, 8);
    drive(4'h0, 4'h0, 4'b1011, 0, 0, 0, 8);
    drive(4'b1011, 4'b0100, 4'hF, 0, 0, 0, 6);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 0, 3);
    drive(4'h0, 4'h0, 4'hF, 1, 0, 0, 3);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 0, 4);
    drive(4'h0, 4'h0, 4'hF, 0, 1, 0, 1);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 0, 3);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 1, 1);
    drive(4'h0, 4'h0, 4'hF, 0, 0, 0, 4);
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] e, ae, c;
      for (int i = 0; i < 4; i++) begin
        e[i]  = ($urandom_range(3) == 0);
        ae[i] = ($urandom_range(2) == 0);
        c[i]  = ($urandom_range(7) != 0);
      end
      drive(e, ae, c, ($urandom_range(9) == 0), ($urandom_range(19) == 0),
            ($urandom_range(199) == 0), 1);
    end
    drive(4'hF, 4'h0, 4'hF, 1, 0, 0, 6);
    @(negedge clk);
    #1;
    chk("drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_arbiter.md
FC_ARBITER -- requirements
Module: fc_arbiter

Interface
REQ-001 Parameter WIDTH, default 6, data word width of each source FIFO and of the destination.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 empty  input  4  registered empty flags of source FIFOs 0-3 (one cycle behind the FIFOs).
REQ-005 almost_empty  input  4  registered almost-empty flags of source FIFOs 0-3.
REQ-006 cf  input  4  registered per-source continue (1 = source may be served).
REQ-007 almost_full_out  input  1  registered almost-full flag of destination FIFO.
REQ-008 full_out  input  1  registered full flag of destination FIFO.
REQ-009 data_in0..data_in3  input  WIDTH each  source FIFO read data, valid the cycle after that source's pop.
REQ-010 pop  output  4  one-hot read strobe to source FIFOs.
REQ-011 push  output  1  write strobe to destination FIFO.
REQ-012 data_out  output  WIDTH  registered word to destination FIFO.
REQ-013 state  output  2  FSM state: IDLE=0, SERVE=1, STALL=2.
REQ-014 grant  output  2  index of the last source popped.

Function
REQ-015 Source i SHALL be eligible when empty[i]=0 and cf[i]=1, except per REQ-016.
REQ-016 Source i popped in cycle N SHALL be ineligible in N+1 unless almost_empty[i]=0 in N+1 (stale-flag underflow guard).
REQ-017 stall SHALL be almost_full_out OR full_out.
REQ-018 pop SHALL be combinational: at most one bit high; high only when state=SERVE or IDLE, stall=0, and at least one source is eligible.
REQ-019 Selection SHALL be round-robin: search starts at (grant+1) mod 4 and wraps; the first eligible source wins.
REQ-020 grant SHALL update to the popped index on the edge ending the pop cycle; unchanged otherwise.
REQ-021 Pipeline: pop[i] in cycle N -> data_in_i sampled at end of N+1 -> push=1 and data_out valid in cycle N+2.
REQ-022 push SHALL be high exactly one cycle per pop; back-to-back pops SHALL give back-to-back pushes.
REQ-023 data_out SHALL hold its last value when push=0.
REQ-024 A pop already issued SHALL complete its push even if stall rises afterward (up to 2 words in flight).
REQ-025 FSM transitions, evaluated each edge:
 - IDLE -> SERVE: stall=0 and any source eligible.
 - IDLE/SERVE -> STALL: stall=1 (priority over all other transitions).
 - SERVE -> IDLE: stall=0 and no source eligible.
 - STALL -> IDLE: stall=0; no pop is issued while in STALL (one-cycle hysteresis).
REQ-026 Simultaneous eligibility of all four sources SHALL be served in order grant+1, grant+2, ... with no source skipped.
REQ-027 cf[i] falling SHALL remove source i from selection in that same cycle; in-flight words of i SHALL still be pushed.

Reset
REQ-028 While reset=1: pop=0, push=0, data_out=0, state=IDLE, grant=3 (first search starts at source 0), pipeline valid bits cleared.
REQ-029 Reset asserted mid-operation SHALL discard in-flight words (no push after reset is released).
REQ-030 First pop after reset release SHALL be possible in the first cycle with reset=0.

Verification
REQ-031 After reset, empty=4'b1110, cf=4'b1111, stall=0, data_in0=6'h15 -> pop=4'b0001 in cycle 0; push=1, data_out=6'h15 in cycle 2; grant=0.
REQ-032 All four sources non-empty, almost_empty=0, cf=4'hF, grant=3 -> pop sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; five consecutive pushes.
REQ-033 Source 2 alone, almost_empty[2]=1, empty[2]=0 -> pop=4'b0100 in cycle N, pop=0 in N+1; pop again in N+2 only if empty[2] is still 0.
REQ-034 almost_full_out rises in the cycle after pops in N-1 and N -> no pop that cycle, state=STALL next edge, two pushes still occur; almost_full_out falls -> one cycle in IDLE, then pops resume.
REQ-035 cf=4'b1011 with all sources non-empty -> source 2 is never popped; order 0, 1, 3, 0.
REQ-036 Reset pulse in the cycle after a pop -> push stays 0 after release; state=IDLE, grant=3.
